// File: rtl/obi_sram_responder.sv
// OBI responder in front of a register-based word memory, with a
// programmable grant stall to emulate slow memory for initiator FSMs.
//
// Ports:
//   clk_i, rst_ni     clock, synchronous active-low reset
//   obi_req_i         request valid
//   obi_gnt_o         grant; accept = req & gnt
//   obi_addr_i        byte address (bits [1:0] ignored)
//   obi_we_i          1 = write, 0 = read
//   obi_be_i          byte enables (writes only)
//   obi_wdata_i       write data
//   obi_rvalid_o      one-cycle response pulse, one cycle after accept
//   obi_rdata_o       read data, held until the next response
//   obi_err_o         out-of-range access, valid with rvalid
module obi_sram_responder #(
    parameter int unsigned NUM_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned STALL_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        obi_req_i,
    output logic        obi_gnt_o,
    input  logic [31:0] obi_addr_i,
    input  logic        obi_we_i,
    input  logic [3:0]  obi_be_i,
    input  logic [31:0] obi_wdata_i,
    output logic        obi_rvalid_o,
    output logic [31:0] obi_rdata_o,
    output logic        obi_err_o
);

    localparam int unsigned IDX_W =
        (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    // Counter preload on leaving IDLE; unused when there is no stall.
    localparam logic [3:0] STALL_LOAD =
        (STALL_CYCLES == 0) ? 4'd0 : 4'(STALL_CYCLES - 1);

    typedef enum logic {
        IDLE,
        STALL
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic        gnt;
    logic        accept;

    // ------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------
    logic [31:0]      off;
    logic [29:0]      idx_full;
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic [1:0]       unused_off;

    assign off        = obi_addr_i - BASE_ADDR;
    assign idx_full   = off[31:2];
    assign idx        = idx_full[IDX_W-1:0];
    assign unused_off = off[1:0];

    // The subtraction wraps, so addresses below the base must be
    // rejected explicitly rather than through the index compare.
    assign in_range = (obi_addr_i >= BASE_ADDR) &&
                      ({2'b00, idx_full} < 32'(NUM_WORDS));

    // ------------------------------------------------------------
    // Grant FSM
    // ------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // No grant is ever given while reset is asserted, so nothing is
    // accepted (or written) during a reset cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        if (rst_ni) begin
            unique case (state_q)
                IDLE: begin
                    if (STALL_CYCLES == 0) begin
                        gnt = obi_req_i;
                    end else if (obi_req_i) begin
                        cnt_d   = STALL_LOAD;
                        state_d = STALL;
                    end
                end
                STALL: begin
                    if (!obi_req_i) begin
                        state_d = IDLE;
                    end else if (cnt_q == 4'd0) begin
                        gnt     = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign obi_gnt_o = gnt;
    assign accept    = obi_req_i & gnt;

    // ------------------------------------------------------------
    // Word memory (contents survive reset)
    // ------------------------------------------------------------
    logic [31:0] mem [NUM_WORDS];

    always_ff @(posedge clk_i) begin
        if (accept && obi_we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (obi_be_i[b]) begin
                    mem[idx][8*b +: 8] <= obi_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------
    logic        rvalid_q;
    logic        err_q;
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            rvalid_q <= accept;
            err_q    <= accept && !in_range;
            if (accept) begin
                rdata_q <= (!obi_we_i && in_range) ? mem[idx] : 32'h0;
            end
        end
    end

    // A reset arriving in the response cycle cancels that response.
    assign obi_rvalid_o = rvalid_q & rst_ni;
    assign obi_err_o    = err_q & rst_ni;
    assign obi_rdata_o  = rdata_q;

endmodule

// File: tb/tb_obi_sram_responder.sv
// Bench for obi_sram_responder: three instances (no stall, 3-cycle
// stall, small offset memory) against a transaction-level model.
module tb_obi_sram_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [2:0]  gnt;
    logic [2:0]  we;
    logic [2:0]  rvalid;
    logic [2:0]  err;
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic [3:0]  be    [3];

    int checks   = 0;
    int failures = 0;
    bit armed    = 1'b0;

    always #5 clk = ~clk;

    obi_sram_responder #(
        .NUM_WORDS(1024), .BASE_ADDR(32'h0), .STALL_CYCLES(0)
    ) u0 (
        .clk_i(clk), .rst_ni(rst_n),
        .obi_req_i(req[0]), .obi_gnt_o(gnt[0]),
        .obi_addr_i(addr[0]), .obi_we_i(we[0]),
        .obi_be_i(be[0]), .obi_wdata_i(wdata[0]),
        .obi_rvalid_o(rvalid[0]), .obi_rdata_o(rdata[0]),
        .obi_err_o(err[0])
    );

    obi_sram_responder #(
        .NUM_WORDS(1024), .BASE_ADDR(32'h0), .STALL_CYCLES(3)
    ) u1 (
        .clk_i(clk), .rst_ni(rst_n),
        .obi_req_i(req[1]), .obi_gnt_o(gnt[1]),
        .obi_addr_i(addr[1]), .obi_we_i(we[1]),
        .obi_be_i(be[1]), .obi_wdata_i(wdata[1]),
        .obi_rvalid_o(rvalid[1]), .obi_rdata_o(rdata[1]),
        .obi_err_o(err[1])
    );

    obi_sram_responder #(
        .NUM_WORDS(16), .BASE_ADDR(32'h1000), .STALL_CYCLES(0)
    ) u2 (
        .clk_i(clk), .rst_ni(rst_n),
        .obi_req_i(req[2]), .obi_gnt_o(gnt[2]),
        .obi_addr_i(addr[2]), .obi_we_i(we[2]),
        .obi_be_i(be[2]), .obi_wdata_i(wdata[2]),
        .obi_rvalid_o(rvalid[2]), .obi_rdata_o(rdata[2]),
        .obi_err_o(err[2])
    );

    function automatic int stl(input int i);
        return (i == 1) ? 3 : 0;
    endfunction

    function automatic logic [31:0] base(input int i);
        return (i == 2) ? 32'h1000 : 32'h0;
    endfunction

    function automatic int nw(input int i);
        return (i == 2) ? 16 : 1024;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
        end
    endtask

    // ------------------------------------------------------------
    // Model: a request run is granted once it has been waiting for
    // STALL cycles; an accepted transfer is answered next cycle.
    // ------------------------------------------------------------
    logic [31:0] mm [int];
    int          waited  [3];
    bit          pend    [3];
    logic [31:0] pr_data [3];
    bit          pr_err  [3];
    logic [31:0] last_rd [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            waited[i]  = 0;
            pend[i]    = 1'b0;
            pr_data[i] = 32'h0;
            pr_err[i]  = 1'b0;
            last_rd[i] = 32'h0;
        end
    end

    always @(negedge clk) begin
        logic [31:0] off;
        bit          inr;
        bit          eg;
        bit          erv;
        int          k;
        if (armed) begin
            for (int i = 0; i < 3; i++) begin
                off = addr[i] - base(i);
                inr = (addr[i] >= base(i)) && ((off >> 2) < 32'(nw(i)));
                k   = i * 65536 + int'(off >> 2);
                eg  = rst_n && req[i] && (waited[i] == stl(i));
                erv = pend[i] && rst_n;

                chk($sformatf("cmp_gnt%0d", i), 32'(gnt[i]), 32'(eg));
                chk($sformatf("cmp_rvalid%0d", i), 32'(rvalid[i]),
                    32'(erv));
                if (erv) begin
                    chk($sformatf("cmp_rdata%0d", i), rdata[i],
                        pr_data[i]);
                    chk($sformatf("cmp_err%0d", i), 32'(err[i]),
                        32'(pr_err[i]));
                    last_rd[i] = pr_data[i];
                end else if (rst_n) begin
                    chk($sformatf("cmp_err_idle%0d", i), 32'(err[i]), 0);
                    chk($sformatf("cmp_rdata_hold%0d", i), rdata[i],
                        last_rd[i]);
                end

                pend[i] = eg;
                if (eg) begin
                    pr_err[i]  = !inr;
                    pr_data[i] = 32'h0;
                    if (inr && !we[i]) begin
                        pr_data[i] = mm.exists(k) ? mm[k] : 32'h0;
                    end
                    if (inr && we[i]) begin
                        if (!mm.exists(k)) mm[k] = 32'h0;
                        for (int b = 0; b < 4; b++) begin
                            if (be[i][b]) mm[k][8*b +: 8] = wdata[i][8*b +: 8];
                        end
                    end
                end
                if (!rst_n || !req[i] || eg) waited[i] = 0;
                else waited[i] = waited[i] + 1;
                if (!rst_n) last_rd[i] = 32'h0;
            end
        end
    end

    // ------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------
    task automatic drive(input int i, input bit r, input bit w,
                         input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d);
        req[i]   = r;
        we[i]    = w;
        addr[i]  = a;
        be[i]    = b;
        wdata[i] = d;
    endtask

    task automatic xfer(input int i, input bit w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d,
                        output logic [31:0] rd, output logic er,
                        output int gcyc);
        @(posedge clk);
        #1 drive(i, 1'b1, w, a, b, d);
        gcyc = 0;
        forever begin
            @(negedge clk);
            if (gnt[i] === 1'b1) break;
            gcyc++;
            if (gcyc > 40) begin
                chk("xfer_gnt_timeout", 32'(gcyc), 32'(stl(i)));
                break;
            end
        end
        @(posedge clk);
        #1 req[i] = 1'b0;
        @(negedge clk);
        chk($sformatf("xfer_rvalid%0d", i), 32'(rvalid[i]), 1);
        rd = rdata[i];
        er = err[i];
    endtask

    logic [31:0] rd;
    logic        er;
    int          g;
    logic [9:0]  gv;
    logic [9:0]  vv;
    logic [31:0] dv [10];

    initial begin
        rst_n = 1'b0;
        req   = '0;
        we    = '0;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

        @(posedge clk);
        #1 armed = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_rdata%0d", i), rdata[i], 32'h0);
            chk($sformatf("rst_rvalid%0d", i), 32'(rvalid[i]), 0);
            chk($sformatf("rst_err%0d", i), 32'(err[i]), 0);
            chk($sformatf("rst_gnt%0d", i), 32'(gnt[i]), 0);
        end

        // Full write then read, no stall
        xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, er, g);
        chk("t1_wr_lat", 32'(g), 0);
        chk("t1_wr_err", 32'(er), 0);
        chk("t1_wr_rdata", rd, 32'h0);
        xfer(0, 1'b0, 32'h10, 4'h0, 32'h0, rd, er, g);
        chk("t1_rd_lat", 32'(g), 0);
        chk("t1_rd_data", rd, 32'hDEADBEEF);
        chk("t1_rd_err", 32'(er), 0);

        // Partial byte enables
        xfer(0, 1'b1, 32'h10, 4'b0101, 32'h11223344, rd, er, g);
        xfer(0, 1'b0, 32'h13, 4'h0, 32'h0, rd, er, g);
        chk("t2_be_data", rd, 32'hDE22BE44);

        // Stall of 3, second request issued in the response cycle
        @(posedge clk);
        #1 drive(1, 1'b1, 1'b1, 32'h0, 4'hF, 32'hA5A5A5A5);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            gv[c] = gnt[1];
            vv[c] = rvalid[1];
            dv[c] = rdata[1];
            @(posedge clk);
            #1;
            if (c == 3) drive(1, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
            if (c == 7) req[1] = 1'b0;
        end
        chk("t3_gnt_cycles", 32'(gv), 32'h088);
        chk("t3_rvalid_cycles", 32'(vv), 32'h110);
        chk("t3_rd_data", dv[8], 32'hA5A5A5A5);

        // Back-to-back reads overlapping responses
        xfer(0, 1'b1, 32'h0, 4'hF, 32'h1, rd, er, g);
        xfer(0, 1'b1, 32'h4, 4'hF, 32'h2, rd, er, g);
        xfer(0, 1'b1, 32'h8, 4'hF, 32'h3, rd, er, g);
        @(posedge clk);
        #1 drive(0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            gv[c] = gnt[0];
            vv[c] = rvalid[0];
            dv[c] = rdata[0];
            @(posedge clk);
            #1;
            if (c == 0) addr[0] = 32'h4;
            if (c == 1) addr[0] = 32'h8;
            if (c == 2) req[0] = 1'b0;
        end
        chk("t4_gnt", 32'(gv[3:0]), 32'h7);
        chk("t4_rvalid", 32'(vv[3:0]), 32'hE);
        chk("t4_d1", dv[1], 32'h1);
        chk("t4_d2", dv[2], 32'h2);
        chk("t4_d3", dv[3], 32'h3);

        // Offset memory: range boundaries and error responses
        xfer(2, 1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, rd, er, g);
        xfer(2, 1'b1, 32'h103C, 4'hF, 32'h12345678, rd, er, g);
        chk("t5_last_word_err", 32'(er), 0);
        xfer(2, 1'b0, 32'h0FFC, 4'h0, 32'h0, rd, er, g);
        chk("t5_below_err", 32'(er), 1);
        chk("t5_below_data", rd, 32'h0);
        xfer(2, 1'b0, 32'h1040, 4'h0, 32'h0, rd, er, g);
        chk("t5_above_err", 32'(er), 1);
        chk("t5_above_data", rd, 32'h0);
        xfer(2, 1'b1, 32'h1040, 4'hF, 32'hFFFFFFFF, rd, er, g);
        chk("t5_wr_above_err", 32'(er), 1);
        xfer(2, 1'b0, 32'h1000, 4'h0, 32'h0, rd, er, g);
        chk("t5_base_data", rd, 32'hCAFEF00D);
        chk("t5_base_err", 32'(er), 0);
        xfer(2, 1'b0, 32'h103C, 4'h0, 32'h0, rd, er, g);
        chk("t5_last_data", rd, 32'h12345678);

        // Write accepted right before reset is committed
        @(posedge clk);
        #1 drive(0, 1'b1, 1'b1, 32'h20, 4'hF, 32'h55AA55AA);
        @(negedge clk);
        chk("t6_wr_gnt", 32'(gnt[0]), 1);
        @(posedge clk);
        #1 req[0] = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_wr_rst_rvalid", 32'(rvalid[0]), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset in the cycle after a read accept
        drive(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        @(negedge clk);
        chk("t6_rd_gnt", 32'(gnt[0]), 1);
        @(posedge clk);
        #1 req[0] = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rd_rst_rvalid", 32'(rvalid[0]), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset while stalling
        drive(1, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("t6_stall_gnt0", 32'(gnt[1]), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t6_stall_gnt1", 32'(gnt[1]), 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("t6_stall_rst_gnt", 32'(gnt[1]), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        req[1] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t6_post_rst_rdata%0d", i), rdata[i], 32'h0);
        end

        xfer(1, 1'b0, 32'h0, 4'h0, 32'h0, rd, er, g);
        chk("t6_stall_restart_lat", 32'(g), 3);
        chk("t6_stall_mem", rd, 32'hA5A5A5A5);
        xfer(0, 1'b0, 32'h20, 4'h0, 32'h0, rd, er, g);
        chk("t6_wr_before_rst", rd, 32'h55AA55AA);
        xfer(0, 1'b0, 32'h10, 4'h0, 32'h0, rd, er, g);
        chk("t6_mem_survives", rd, 32'hDE22BE44);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
